// File: rtl/encoder_pos_ctrl_if.sv
// Handshake/status bundle between the encoder step source, the motion logic
// and encoder_pos_ctrl. The master drives the step, index and command inputs.
interface encoder_pos_ctrl_if #(
  parameter int POS_W = 16,
  parameter int VEL_W = 12
);
  logic                    plus1;
  logic                    minus1;
  logic                    index;
  logic                    home_req;
  logic                    clear_fault;
  logic signed [POS_W-1:0] position;
  logic signed [VEL_W-1:0] velocity;
  logic                    vel_valid;
  logic [1:0]              state;
  logic                    homed;
  logic                    fault;
  logic                    glitch;

  modport master (
    output plus1, minus1, index, home_req, clear_fault,
    input  position, velocity, vel_valid, state, homed, fault, glitch
  );

  modport slave (
    input  plus1, minus1, index, home_req, clear_fault,
    output position, velocity, vel_valid, state, homed, fault, glitch
  );
endinterface

// File: rtl/encoder_pos_ctrl.sv
// Absolute position tracking from encoder step pulses, index-based homing with
// timeout, soft travel limits in TRACK, and a windowed net-step velocity.
module encoder_pos_ctrl #(
  parameter int POS_W   = 16,
  parameter int VEL_W   = 12,
  parameter int VEL_WIN = 1000,
  parameter int POS_MAX = 30000,
  parameter int POS_MIN = -30000,
  parameter int HOME_TO = 100000
) (
  input  logic              clk,
  input  logic              reset,
  encoder_pos_ctrl_if.slave bus
);
  localparam int TO_W  = $clog2(HOME_TO + 1);
  localparam int WIN_W = $clog2(VEL_WIN);
  localparam logic signed [POS_W:0] MAX_EXT  = (POS_W+1)'(POS_MAX);
  localparam logic signed [POS_W:0] MIN_EXT  = (POS_W+1)'(POS_MIN);
  localparam logic signed [VEL_W:0] VMAX_EXT = {2'b00, {(VEL_W-1){1'b1}}};
  localparam logic signed [VEL_W:0] VMIN_EXT = {2'b11, {(VEL_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, HOMING = 2'd1, TRACK = 2'd2, FAULT = 2'd3} state_t;

  state_t                  cur_state;
  state_t                  nxt_state;
  logic signed [1:0]       step;
  logic                    glitch_now;
  logic                    index_q;
  logic                    idx_rise;
  logic signed [POS_W:0]   pos_sum;
  logic                    over_max;
  logic                    limit_hit;
  logic                    timeout;
  logic signed [VEL_W:0]   vel_sum;
  logic signed [VEL_W-1:0] vel_sat;
  logic signed [POS_W-1:0] pos_q;
  logic signed [VEL_W-1:0] acc_q;
  logic signed [VEL_W-1:0] vel_q;
  logic                    vel_valid_q;
  logic                    homed_q;
  logic                    glitch_q;
  logic [TO_W-1:0]         to_cnt;
  logic [WIN_W-1:0]        win_cnt;

  // Simultaneous plus1/minus1 is ambiguous, so it counts as no movement.
  always_comb begin
    step = 2'sd0;
    if (bus.plus1 && !bus.minus1) step = 2'sd1;
    else if (bus.minus1 && !bus.plus1) step = -2'sd1;
  end

  assign glitch_now = bus.plus1 & bus.minus1;
  assign idx_rise   = bus.index & ~index_q;
  // One guard bit so an out-of-range sum is seen before it could wrap.
  assign pos_sum    = {pos_q[POS_W-1], pos_q} + {{(POS_W-1){step[1]}}, step};
  assign over_max   = pos_sum > MAX_EXT;
  assign limit_hit  = over_max || (pos_sum < MIN_EXT);
  assign timeout    = (to_cnt == TO_W'(HOME_TO - 1));
  assign vel_sum    = {acc_q[VEL_W-1], acc_q} + {{(VEL_W-1){step[1]}}, step};

  always_comb begin
    vel_sat = vel_sum[VEL_W-1:0];
    if (vel_sum > VMAX_EXT) vel_sat = VMAX_EXT[VEL_W-1:0];
    else if (vel_sum < VMIN_EXT) vel_sat = VMIN_EXT[VEL_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) cur_state <= IDLE;
    else       cur_state <= nxt_state;
  end

  // An index edge beats a homing timeout landing on the same cycle.
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE:    if (bus.home_req) nxt_state = HOMING;
      HOMING:  if (idx_rise) nxt_state = TRACK;
               else if (timeout) nxt_state = FAULT;
      TRACK:   if (limit_hit) nxt_state = FAULT;
               else if (bus.home_req) nxt_state = HOMING;
      default: if (bus.clear_fault) nxt_state = IDLE;
    endcase
  end

  always_comb begin
    bus.state = cur_state;
    bus.fault = (cur_state == FAULT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q    <= '0;
      homed_q  <= 1'b0;
      glitch_q <= 1'b0;
      index_q  <= 1'b0;
      to_cnt   <= '0;
    end else begin
      index_q <= bus.index;
      if (glitch_now) glitch_q <= 1'b1;
      if (nxt_state == HOMING && (cur_state != HOMING || bus.home_req)) to_cnt <= '0;
      else if (cur_state == HOMING) to_cnt <= to_cnt + 1'b1;
      case (cur_state)
        IDLE:   pos_q <= pos_sum[POS_W-1:0];
        HOMING: pos_q <= idx_rise ? '0 : pos_sum[POS_W-1:0];
        TRACK:  if (limit_hit) pos_q <= over_max ? MAX_EXT[POS_W-1:0] : MIN_EXT[POS_W-1:0];
                else pos_q <= pos_sum[POS_W-1:0];
        default: pos_q <= pos_q;
      endcase
      if (nxt_state == FAULT) homed_q <= 1'b0;
      else if (cur_state == HOMING && idx_rise) homed_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt     <= '0;
      acc_q       <= '0;
      vel_q       <= '0;
      vel_valid_q <= 1'b0;
    end else if (win_cnt == WIN_W'(VEL_WIN - 1)) begin
      win_cnt     <= '0;
      acc_q       <= '0;
      vel_q       <= vel_sat;
      vel_valid_q <= 1'b1;
    end else begin
      win_cnt     <= win_cnt + 1'b1;
      acc_q       <= vel_sat;
      vel_valid_q <= 1'b0;
    end
  end

  assign bus.position  = pos_q;
  assign bus.velocity  = vel_q;
  assign bus.vel_valid = vel_valid_q;
  assign bus.homed     = homed_q;
  assign bus.glitch    = glitch_q;
endmodule

// File: tb/tb_encoder_pos_ctrl.sv
// Scoreboard bench for encoder_pos_ctrl: an integer reference model predicts each
// cycle's outputs and every completed velocity window; a monitor compares them.
module tb_encoder_pos_ctrl;
  localparam int POS_W   = 16;
  localparam int VEL_W   = 4;
  localparam int VEL_WIN = 20;
  localparam int POS_MAX = 10;
  localparam int POS_MIN = -10;
  localparam int HOME_TO = 50;
  localparam int VMAX    = 2**(VEL_W-1) - 1;
  localparam int VMIN    = -(2**(VEL_W-1));
  localparam int S_IDLE = 0, S_HOMING = 1, S_TRACK = 2, S_FAULT = 3;

  typedef struct {
    int pos;
    int vv;
    int st;
    int homed;
    int fault;
    int glitch;
  } snap_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  encoder_pos_ctrl_if #(.POS_W(POS_W), .VEL_W(VEL_W)) bus();

  encoder_pos_ctrl #(
    .POS_W(POS_W), .VEL_W(VEL_W), .VEL_WIN(VEL_WIN),
    .POS_MAX(POS_MAX), .POS_MIN(POS_MIN), .HOME_TO(HOME_TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  snap_t exp_q[$];
  int    vel_q[$];
  int    check_count = 0;
  int    pass_count  = 0;

  int m_st, m_pos, m_homed, m_glitch, m_acc, m_phase, m_hcnt, m_idx_prev;

  task automatic check(input string name, input int actual, input int expected);
    check_count++;
    if (actual == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic int wrap_pos(input int x);
    logic signed [POS_W-1:0] t;
    t = x[POS_W-1:0];
    return int'(t);
  endfunction

  function automatic int clamp_vel(input int x);
    if (x > VMAX) return VMAX;
    if (x < VMIN) return VMIN;
    return x;
  endfunction

  // Reference model: what the outputs must read after the edge that samples these inputs.
  task automatic modelStep(input bit p, input bit m, input bit idx, input bit hr,
                           input bit cf, input bit rst);
    int step;
    int sum;
    int vv;
    bit rise;
    vv = 0;
    if (rst) begin
      m_st = S_IDLE; m_pos = 0; m_homed = 0; m_glitch = 0;
      m_acc = 0; m_phase = 0; m_hcnt = 0; m_idx_prev = 0;
    end else begin
      step = (p && !m) ? 1 : ((m && !p) ? -1 : 0);
      if (p && m) m_glitch = 1;
      rise = idx && !m_idx_prev;
      m_idx_prev = idx;
      m_acc = clamp_vel(m_acc + step);
      if (m_phase == VEL_WIN - 1) begin
        vel_q.push_back(m_acc);
        vv = 1; m_acc = 0; m_phase = 0;
      end else begin
        m_phase++;
      end
      case (m_st)
        S_IDLE: begin
          m_pos = wrap_pos(m_pos + step);
          if (hr) begin m_st = S_HOMING; m_hcnt = 0; end
        end
        S_HOMING: begin
          if (rise) begin
            m_pos = 0; m_homed = 1; m_st = S_TRACK;
          end else if (m_hcnt == HOME_TO - 1) begin
            m_pos = wrap_pos(m_pos + step); m_homed = 0; m_st = S_FAULT;
          end else begin
            m_pos = wrap_pos(m_pos + step);
            m_hcnt = hr ? 0 : m_hcnt + 1;
          end
        end
        S_TRACK: begin
          sum = m_pos + step;
          if (sum > POS_MAX) begin
            m_pos = POS_MAX; m_homed = 0; m_st = S_FAULT;
          end else if (sum < POS_MIN) begin
            m_pos = POS_MIN; m_homed = 0; m_st = S_FAULT;
          end else begin
            m_pos = sum;
            if (hr) begin m_st = S_HOMING; m_hcnt = 0; end
          end
        end
        default: if (cf) m_st = S_IDLE;
      endcase
    end
    exp_q.push_back('{m_pos, vv, m_st, m_homed, (m_st == S_FAULT) ? 1 : 0, m_glitch});
  endtask

  task automatic applyStimulus(input bit p, input bit m, input bit idx, input bit hr,
                               input bit cf, input bit rst);
    @(negedge clk);
    bus.plus1       = p;
    bus.minus1      = m;
    bus.index       = idx;
    bus.home_req    = hr;
    bus.clear_fault = cf;
    reset           = rst;
    modelStep(p, m, idx, hr, cf, rst);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input snap_t e);
    check("position", int'(bus.position), e.pos);
    check("vel_valid", int'(bus.vel_valid), e.vv);
    check("state", int'(bus.state), e.st);
    check("homed", int'(bus.homed), e.homed);
    check("fault", int'(bus.fault), e.fault);
    check("glitch", int'(bus.glitch), e.glitch);
    if (bus.vel_valid) begin
      if (vel_q.size() == 0) begin
        check_count++;
        $display("[TB] FAIL velocity: pulse with no window expected, got %0d", int'(bus.velocity));
      end else begin
        check("velocity", int'(bus.velocity), vel_q.pop_front());
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    int n;
    int r;
    bit p, m, idx, hr, cf, rst;
    int p_pct[4] = '{30, 70, 10, 45};
    int m_pct[4] = '{30, 10, 70, 45};

    bus.plus1 = 1'b0; bus.minus1 = 1'b0; bus.index = 1'b0;
    bus.home_req = 1'b0; bus.clear_fault = 1'b0;

    repeat (2) applyStimulus(0, 0, 0, 0, 0, 1);
    settle();
    check("reset_position", int'(bus.position), 0);
    check("reset_velocity", int'(bus.velocity), 0);
    check("reset_state", int'(bus.state), 0);
    check("reset_flags", int'({bus.homed, bus.fault, bus.glitch, bus.vel_valid}), 0);

    for (int i = 0; i < VEL_WIN; i++)
      applyStimulus(i < 7, (i >= 7 && i < 9), 0, 0, 0, 0);
    settle();
    check("win1_vel_valid", int'(bus.vel_valid), 1);
    check("win1_velocity", int'(bus.velocity), 5);
    repeat (VEL_WIN) applyStimulus(0, 0, 0, 0, 0, 0);
    settle();
    check("win2_velocity", int'(bus.velocity), 0);

    applyStimulus(0, 0, 0, 1, 0, 0);
    repeat (3) applyStimulus(0, 1, 0, 0, 0, 0);
    settle();
    check("homing_position", int'(bus.position), 2);
    check("homing_state", int'(bus.state), S_HOMING);
    applyStimulus(0, 0, 1, 0, 0, 0);
    settle();
    check("homed_position", int'(bus.position), 0);
    check("homed_state", int'(bus.state), S_TRACK);
    check("homed_flag", int'(bus.homed), 1);
    applyStimulus(0, 0, 0, 0, 0, 0);

    repeat (12) applyStimulus(1, 0, 0, 0, 0, 0);
    settle();
    check("limit_position", int'(bus.position), POS_MAX);
    check("limit_state", int'(bus.state), S_FAULT);
    check("limit_homed", int'(bus.homed), 0);
    repeat (3) applyStimulus(1, 0, 0, 1, 0, 0);
    settle();
    check("fault_hold_position", int'(bus.position), POS_MAX);
    check("fault_ignores_home", int'(bus.state), S_FAULT);
    applyStimulus(0, 0, 0, 0, 1, 0);
    settle();
    check("clear_fault_state", int'(bus.state), S_IDLE);

    applyStimulus(1, 1, 0, 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);
    settle();
    check("glitch_position", int'(bus.position), POS_MAX);
    check("glitch_sticky", int'(bus.glitch), 1);

    applyStimulus(0, 0, 0, 1, 0, 0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    settle();
    check("index_beats_step", int'(bus.position), 0);
    check("index_state", int'(bus.state), S_TRACK);
    applyStimulus(0, 0, 0, 0, 0, 0);

    applyStimulus(0, 0, 0, 1, 0, 0);
    settle();
    n = 0;
    while (bus.state != 2'(S_FAULT) && n < HOME_TO + 10) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      settle();
      n++;
    end
    check("timeout_cycles", n, HOME_TO);
    check("timeout_homed", int'(bus.homed), 0);
    applyStimulus(0, 0, 0, 0, 1, 0);

    idx = 0;
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 600; i++) begin
        r = int'($urandom_range(0, 99));
        p = (r < p_pct[ph]) || (r == 99);
        m = (r >= p_pct[ph] && r < p_pct[ph] + m_pct[ph]) || (r == 99);
        if ($urandom_range(0, 99) < 6) idx = ~idx;
        hr  = $urandom_range(0, 99) < 3;
        cf  = $urandom_range(0, 99) < 8;
        rst = $urandom_range(0, 999) < 3;
        applyStimulus(p, m, idx, hr, cf, rst);
      end
    end
    applyStimulus(0, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #2;
    check("velocity_queue_drained", vel_q.size(), 0);
    check("expect_queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule

// File: doc/encoder_pos_ctrl.md
Name: encoder_pos_ctrl

Overview:
Position/homing controller sitting directly downstream of the quadrature `encoder` block. It consumes the encoder's single-cycle `plus1`/`minus1` step pulses and maintains a signed absolute position. It sequences a homing cycle against an index marker, enforces soft travel limits, and produces a windowed velocity measurement for the motion logic above it.

Parameters:
POS_W, 16, position width in bits (signed two's complement).
VEL_W, 12, velocity width in bits (signed; net steps per window).
VEL_WIN, 1000, velocity window length in clk cycles (>=2).
POS_MAX, 30000, upper soft limit (signed, must fit POS_W).
POS_MIN, -30000, lower soft limit (signed, POS_MIN < 0 < POS_MAX).
HOME_TO, 100000, homing timeout in clk cycles.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
plus1  in  1  one-cycle forward step pulse from encoder
minus1  in  1  one-cycle reverse step pulse from encoder
index  in  1  home/index marker level, already synchronous to clk
home_req  in  1  one-cycle request to start homing
clear_fault  in  1  one-cycle request to leave FAULT
position  out  POS_W  signed absolute position
velocity  out  VEL_W  signed net steps over last completed window
vel_valid  out  1  one-cycle pulse when velocity updates
state  out  2  0=IDLE 1=HOMING 2=TRACK 3=FAULT
homed  out  1  high once homing completed; cleared on reset/FAULT
fault  out  1  high while in FAULT
glitch  out  1  sticky: plus1 and minus1 seen high together

Behaviour:
- Clock and reset: one clock `clk`. `reset` is synchronous and active-high.
- Reset values: all outputs 0; state=IDLE; internal counters 0; the index delay flop is 0.
- Step decode, every cycle:
  - step = +1 if plus1&~minus1.
  - step = -1 if minus1&~plus1.
  - step = 0 otherwise.
  - plus1&minus1 together sets glitch (sticky until reset) and is treated as step 0.
- Index edge: idx_rise = index & ~index_q, with index_q a 1-cycle delay.
- position: updated on the clk edge after the pulse (1-cycle latency) in IDLE, HOMING and TRACK. Frozen in FAULT.
- IDLE:
  - position accumulates; homed=0.
  - home_req -> HOMING, and the timeout counter clears.
  - Limits are not enforced in IDLE.
- HOMING:
  - position accumulates; the timeout counter increments each cycle.
  - idx_rise -> position<=0 (this overrides any step in the same cycle), homed<=1, go to TRACK.
  - Timeout counter reaching HOME_TO-1 without idx_rise -> FAULT.
  - If idx_rise and the timeout occur in the same cycle, idx_rise wins.
  - home_req while already HOMING restarts the timeout counter.
- TRACK:
  - position accumulates.
  - If position+step > POS_MAX or < POS_MIN: position saturates at that limit and state goes to FAULT in the same edge.
  - home_req -> HOMING (re-home); homed stays 1 until the index is found again.
- FAULT:
  - fault=1, homed<=0, position held.
  - clear_fault -> IDLE next cycle. home_req is ignored in FAULT.
- Priority when events coincide: reset > FAULT entry > idx_rise > home_req > step.
- Velocity:
  - A free-running window counter 0..VEL_WIN-1 runs in all states.
  - A signed net accumulator adds step each cycle, saturating at the VEL_W signed range.
  - On the cycle the counter equals VEL_WIN-1: velocity <= accumulator+step (saturated), vel_valid=1 for that one cycle, accumulator <= 0, counter wraps to 0.
  - Steps in FAULT still count toward velocity.
- Width rules: limit comparison is done at POS_W+1 bits so the position register never wraps.

Test Plan:
- Reset: hold reset 2 cycles -> position=0, velocity=0, state=0, homed=fault=glitch=vel_valid=0.
- Homing: 5 plus1 pulses in IDLE (position=5), then home_req, then 3 minus1 (position=2), then index rises -> position=0 next cycle, state=2, homed=1.
- Limit: POS_MAX=10, homed TRACK, 12 plus1 pulses -> position stops at 10, state=3, fault=1, homed=0. Further pulses leave position at 10. clear_fault -> state=0.
- Timeout: HOME_TO=50, home_req with index held low -> FAULT exactly 50 cycles after entering HOMING.
- Velocity: VEL_WIN=20, 7 plus1 and 2 minus1 within one window -> vel_valid pulses at cycle 19 with velocity=5. Next window with no steps -> velocity=0.
- Glitch/priority: plus1=minus1=1 for one cycle -> position unchanged, glitch=1 and stays 1. idx_rise coincident with minus1 in HOMING -> position=0.
